ibex_data_bus_arbiter: RTL and testbench

Two-host arbiter that shares the core's single data-memory port between the load/store unit (host 0) and a secondary data master (host 1, e.g. DMA or debug access). It sits between the LSU's data bus outputs and the external data interface. It forwards one request at a time, holds the selection stable until grant, and routes in-order responses back to the issuing host using an outstanding-transaction ID FIFO.

---
 rtl/ibex_data_bus_arbiter_pkg.sv | 26 ++
 rtl/ibex_data_bus_id_fifo.sv | 59 +++++
 rtl/ibex_data_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_ibex_data_bus_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ibex_data_bus_arbiter_pkg.sv
// Shared types and constants for the two-host data bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ibex_data_bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic HOST_LSU = 1'b0;
    localparam logic HOST_AUX = 1'b1;

    // Request attributes of the selected host, muxed as one bundle.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
    } req_attr_t;

    // One-hot per-host vector for a host index.
    function automatic logic [1:0] host_onehot(input logic host);
        return host ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ibex_data_bus_id_fifo.sv
// In-order FIFO of 1-bit source-host IDs for outstanding transactions.
// Latency: head is registered; a pushed entry is visible at the head the cycle after push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module ibex_data_bus_id_fifo #(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            wdata_i,
    input  logic            pop_i,
    output logic            rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop frees a slot in the same cycle, so push+pop is accepted even when full.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ibex_data_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU and an auxiliary master.
// Latency: zero-cycle request/grant path; responses routed combinationally from the registered ID FIFO head.
// Backpressure: selection is held until downstream grant; no request is issued while MaxOutstanding responses are pending.
module ibex_data_bus_arbiter
    import ibex_data_bus_arbiter_pkg::*;
#(
    parameter int unsigned MemDataWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [1:0]                   h_req_i,
    output logic [1:0]                   h_gnt_o,
    output logic [1:0]                   h_rvalid_o,
    output logic [1:0]                   h_err_o,
    input  logic [1:0][31:0]             h_addr_i,
    input  logic [1:0]                   h_we_i,
    input  logic [1:0][3:0]              h_be_i,
    input  logic [1:0][MemDataWidth-1:0] h_wdata_i,
    output logic [MemDataWidth-1:0]      h_rdata_o,
    output logic                         data_req_o,
    output logic [31:0]                  data_addr_o,
    output logic                         data_we_o,
    output logic [3:0]                   data_be_o,
    output logic [MemDataWidth-1:0]      data_wdata_o,
    input  logic                         data_gnt_i,
    input  logic                         data_rvalid_i,
    input  logic                         data_err_i,
    input  logic [MemDataWidth-1:0]      data_rdata_i,
    output logic                         busy_o,
    output logic                         spurious_rvalid_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q, state_d;
    logic            sel_q, sel_d;
    logic            rr_q, rr_d;
    logic            sel;
    logic            req_gnt;
    logic            can_issue;
    req_attr_t       sel_attr;
    logic            fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_cnt;
    logic            rsp_vld;

    // An in-flight response retires its FIFO entry this cycle, so a full FIFO can still accept a grant.
    assign can_issue = ~fifo_full | data_rvalid_i;

    // Host selection, downstream request muxing and arbitration next state.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        sel      = HOST_LSU;
        req_gnt  = 1'b0;
        sel_attr = '0;

        if (state_q == ARB_LOCKED) begin
            sel = sel_q;
        end else begin
            unique case (h_req_i)
                2'b01:   sel = HOST_LSU;
                2'b10:   sel = HOST_AUX;
                2'b11:   sel = rr_q;
                default: sel = HOST_LSU;
            endcase
        end

        sel_attr   = '{addr: h_addr_i[sel], we: h_we_i[sel], be: h_be_i[sel]};
        data_req_o = h_req_i[sel] & can_issue;
        req_gnt    = data_req_o & data_gnt_i;

        if (state_q == ARB_LOCKED) begin
            if (req_gnt) begin
                state_d = ARB_IDLE;
                rr_d    = ~sel_q;
            end
        end else if (|h_req_i) begin
            if (req_gnt) begin
                rr_d = ~sel;
            end else begin
                state_d = ARB_LOCKED;
                sel_d   = sel;
            end
        end
    end

    assign data_addr_o  = sel_attr.addr;
    assign data_we_o    = sel_attr.we;
    assign data_be_o    = sel_attr.be;
    assign data_wdata_o = h_wdata_i[sel];
    assign h_gnt_o      = req_gnt ? host_onehot(sel) : 2'b00;

    // Arbitration state, locked host and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            sel_q   <= HOST_LSU;
            rr_q    <= HOST_LSU;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    ibex_data_bus_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_gnt),
        .wdata_i (sel),
        .pop_i   (data_rvalid_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign rsp_vld           = data_rvalid_i & ~fifo_empty;
    assign h_rvalid_o        = rsp_vld ? host_onehot(fifo_head) : 2'b00;
    assign h_err_o           = (rsp_vld & data_err_i) ? host_onehot(fifo_head) : 2'b00;
    assign h_rdata_o         = data_rdata_i;
    assign spurious_rvalid_o = data_rvalid_i & fifo_empty;
    assign busy_o            = (fifo_cnt != '0) | (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Self-checking bench for the two-host data bus arbiter.
// Latency: expected hosts queued at grant, compared at response.
// Backpressure: driven directly through data_gnt_i and FIFO occupancy.
module tb_ibex_data_bus_arbiter;

    localparam int unsigned W = 32;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic [1:0]       h_req_i = '0;
    logic [1:0]       h_gnt_o;
    logic [1:0]       h_rvalid_o;
    logic [1:0]       h_err_o;
    logic [1:0][31:0] h_addr_i;
    logic [1:0]       h_we_i;
    logic [1:0][3:0]  h_be_i;
    logic [1:0][W-1:0] h_wdata_i;
    logic [W-1:0]     h_rdata_o;
    logic             data_req_o;
    logic [31:0]      data_addr_o;
    logic             data_we_o;
    logic [3:0]       data_be_o;
    logic [W-1:0]     data_wdata_o;
    logic             data_gnt_i = 1'b0;
    logic             data_rvalid_i = 1'b0;
    logic             data_err_i = 1'b0;
    logic [W-1:0]     data_rdata_i = '0;
    logic             busy_o;
    logic             spurious_rvalid_o;

    int n_chk = 0;
    int n_bad = 0;
    logic sb[$];

    always #5 clk_i = ~clk_i;

    ibex_data_bus_arbiter #(
        .MemDataWidth   (W),
        .MaxOutstanding (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .h_req_i           (h_req_i),
        .h_gnt_o           (h_gnt_o),
        .h_rvalid_o        (h_rvalid_o),
        .h_err_o           (h_err_o),
        .h_addr_i          (h_addr_i),
        .h_we_i            (h_we_i),
        .h_be_i            (h_be_i),
        .h_wdata_i         (h_wdata_i),
        .h_rdata_o         (h_rdata_o),
        .data_req_o        (data_req_o),
        .data_addr_o       (data_addr_o),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_wdata_o      (data_wdata_o),
        .data_gnt_i        (data_gnt_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .data_rdata_i      (data_rdata_i),
        .busy_o            (busy_o),
        .spurious_rvalid_o (spurious_rvalid_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reset with all host requests low and check the reset state.
    task automatic do_reset();
        rst_ni        = 1'b0;
        h_req_i       = 2'b00;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        #1;
        chk("rst_gnt", h_gnt_o, 2'b00);
        chk("rst_rvalid", h_rvalid_o, 2'b00);
        chk("rst_req", data_req_o, 1'b0);
        chk("rst_addr", data_addr_o, h_addr_i[0]);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_cnt", dut.fifo_cnt, 2'd0);
        chk("rst_rr", dut.rr_q, 1'b0);
        sb.delete();
        tick();
        rst_ni = 1'b1;
    endtask

    // One cycle of stimulus; expected grant given by the caller, expected responder from the scoreboard.
    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic err,
                         input logic [W-1:0] rdata, input logic [1:0] exp_gnt);
        logic       host;
        logic [1:0] exp_rv;
        h_req_i       = req;
        data_gnt_i    = gnt;
        data_rvalid_i = rv;
        data_err_i    = err;
        data_rdata_i  = rdata;
        #1;
        chk("gnt", h_gnt_o, exp_gnt);
        if (rv) begin
            if (sb.size() > 0) begin
                host   = sb.pop_front();
                exp_rv = host ? 2'b10 : 2'b01;
                chk("rvalid", h_rvalid_o, exp_rv);
                chk("err", h_err_o, err ? exp_rv : 2'b00);
                chk("rdata", h_rdata_o, rdata);
                chk("no_spur", spurious_rvalid_o, 1'b0);
            end else begin
                chk("spur", spurious_rvalid_o, 1'b1);
                chk("spur_rvalid", h_rvalid_o, 2'b00);
            end
        end
        if (exp_gnt == 2'b01) sb.push_back(1'b0);
        if (exp_gnt == 2'b10) sb.push_back(1'b1);
        tick();
    endtask

    initial begin
        h_addr_i[0]  = 32'h0000_0100;
        h_addr_i[1]  = 32'h0000_0200;
        h_we_i       = 2'b10;
        h_be_i[0]    = 4'hF;
        h_be_i[1]    = 4'h3;
        h_wdata_i[0] = 32'h1111_1111;
        h_wdata_i[1] = 32'h2222_2222;
        #2;
        do_reset();

        // Single LSU read
        h_req_i = 2'b01; data_gnt_i = 1'b1;
        #1;
        chk("t1_req", data_req_o, 1'b1);
        chk("t1_addr", data_addr_o, 32'h100);
        chk("t1_we", data_we_o, 1'b0);
        chk("t1_be", data_be_o, 4'hF);
        drive(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b01);
        drive(2'b00, 1'b0, 1'b0, 1'b0, '0, 2'b00);
        chk("t1_busy", busy_o, 1'b1);
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 2'b00);
        chk("t1_cnt", dut.fifo_cnt, 2'd0);
        chk("t1_idle", busy_o, 1'b0);

        // Contention: alternating grants with responses overlapping
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(2'b11, 1'b1, i > 0, 1'b0, $urandom, (i % 2 == 1) ? 2'b10 : 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b0, $urandom, 2'b00);

        // Lock on host 1 while host 0 requests, then errors and a spurious response
        do_reset();
        drive(2'b10, 1'b0, 1'b0, 1'b0, '0, 2'b00);
        chk("lk_addr0", data_addr_o, 32'h200);
        chk("lk_wdata", data_wdata_o, 32'h2222_2222);
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 1'b0, 1'b0, 1'b0, '0, 2'b00);
            chk("lk_addr", data_addr_o, 32'h200);
            chk("lk_req", data_req_o, 1'b1);
        end
        drive(2'b11, 1'b1, 1'b0, 1'b0, '0, 2'b10);
        drive(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 1'b1, $urandom, 2'b00);
        drive(2'b00, 1'b0, 1'b1, 1'b0, $urandom, 2'b00);
        drive(2'b00, 1'b0, 1'b1, 1'b0, $urandom, 2'b00);

        // Full FIFO
        do_reset();
        drive(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b01);
        drive(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b01);
        chk("full_cnt", dut.fifo_cnt, 2'd2);
        drive(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b00);
        chk("full_req", data_req_o, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 1'b0, $urandom, 2'b01);
        chk("full_pp_cnt", dut.fifo_cnt, 2'd2);
        drive(2'b00, 1'b0, 1'b1, 1'b0, $urandom, 2'b00);
        drive(2'b00, 1'b0, 1'b1, 1'b0, $urandom, 2'b00);
        chk("full_drain", dut.fifo_cnt, 2'd0);

        // Reset mid-lock with one outstanding transaction
        do_reset();
        drive(2'b01, 1'b1, 1'b0, 1'b0, '0, 2'b01);
        drive(2'b10, 1'b0, 1'b0, 1'b0, '0, 2'b00);
        chk("ml_busy", busy_o, 1'b1);
        do_reset();
        drive(2'b00, 1'b0, 1'b1, 1'b0, $urandom, 2'b00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
